// File: rtl/sim_ctrl.sv
// Simulation control slave on Wishbone classic: halt/exit code, cycle counter,
// signature window registers and a console byte FIFO (enabled by SIM_CTRL_CONSOLE_EN).
`timescale 1ns/1ps

module sim_ctrl #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        halt_o,
  output logic [7:0]  exit_code_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i
);

  typedef enum logic [3:0] {
    REG_HALT      = 4'h0,
    REG_CYCLE     = 4'h1,
    REG_TX        = 4'h2,
    REG_SIG_BEGIN = 4'h3,
    REG_SIG_END   = 4'h4
  } reg_e;

  logic        hit;
  logic        take;
  logic        bad;
  logic        done;
  logic        wr_ok;
  logic        tx_stall;
  logic [3:0]  word;
  logic [4:0]  occupancy;
  logic [31:0] cycle;
  logic [31:0] sig_begin;
  logic [31:0] sig_end;
  logic [31:0] rdata;

  assign hit   = cyc_i & stb_i & (adr_i[31:6] == BASE_ADDRESS[31:6]);
  // A strobe is only taken while no termination is on the bus, so a held
  // strobe cannot be acknowledged twice.
  assign take  = hit & ~ack_o & ~err_o;
  assign word  = adr_i[5:2];
  assign done  = take & ~tx_stall;
  assign wr_ok = done & ~bad & we_i;

  always_comb begin
    bad = 1'b0;
    case (word)
      REG_HALT, REG_TX, REG_SIG_BEGIN, REG_SIG_END: bad = 1'b0;
      REG_CYCLE: bad = we_i;
      default:   bad = 1'b1;
    endcase
    if (adr_i[1:0] != 2'b00) bad = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (word)
      REG_HALT:      rdata = {23'b0, halt_o, exit_code_o};
      REG_CYCLE:     rdata = cycle;
      REG_TX:        rdata = {27'b0, occupancy};
      REG_SIG_BEGIN: rdata = sig_begin;
      REG_SIG_END:   rdata = sig_end;
      default:       rdata = '0;
    endcase
  end

`ifdef SIM_CTRL_CONSOLE_EN
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          push;
  logic          tx_wr;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = tx_valid_o & tx_ready_i;
  assign tx_wr      = take & ~bad & we_i & (word == REG_TX);
  // A pop in the same cycle frees the slot the stalled push needs.
  assign tx_stall   = tx_wr & full & ~pop;
  assign push       = tx_wr & ~tx_stall;
  assign tx_valid_o = (count != '0);
  assign tx_data_o  = mem[rd_ptr];
  assign occupancy  = 5'(count);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`else
  logic unused_cfg;

  assign tx_stall   = 1'b0;
  assign occupancy  = '0;
  assign tx_valid_o = 1'b0;
  assign tx_data_o  = '0;
  assign unused_cfg = ^{tx_ready_i, FIFO_DEPTH};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      dat_o       <= '0;
      halt_o      <= 1'b0;
      exit_code_o <= '0;
      cycle       <= '0;
      sig_begin   <= '0;
      sig_end     <= '0;
    end else begin
      ack_o <= done & ~bad;
      err_o <= done & bad;
      dat_o <= (done & ~bad & ~we_i) ? rdata : '0;
      if (!halt_o) cycle <= cycle + 32'd1;
      if (wr_ok) begin
        case (word)
          REG_HALT: begin
            if (sel_i[0] && !halt_o) begin
              halt_o      <= 1'b1;
              exit_code_o <= dat_i[7:0];
            end
          end
          REG_SIG_BEGIN: begin
            for (int unsigned b = 0; b < 4; b++)
              if (sel_i[b]) sig_begin[b*8 +: 8] <= dat_i[b*8 +: 8];
          end
          REG_SIG_END: begin
            for (int unsigned b = 0; b < 4; b++)
              if (sel_i[b]) sig_end[b*8 +: 8] <= dat_i[b*8 +: 8];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
